// File: rtl/score_pkg.sv
// Shared definitions for the score-to-BCD display path: the default score
// width, the converter FSM encoding, the active-low 7-segment glyphs and a
// constant power-of-ten helper used to size the overflow threshold.
package score_pkg;

  localparam int SCORE_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // 10^n as a 64-bit constant; only evaluated at elaboration time
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// One BCD digit to an active-low 7-segment pattern. Non-decimal codes
// (10-15) blank the digit rather than showing a hex glyph.
module seg7_decode
  import score_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Pure lookup from digit value to glyph
  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/score_bcd_display.sv
// Binary score to packed BCD converter using sequential double-dabble:
// one bit per cycle, WIDTH shift cycles, then a DONE cycle that publishes
// the result (or all nines when the score does not fit in DIGITS digits).
// Optional macro SCORE_BCD_SEG_EN adds a registered per-digit 7-segment
// decode of the published BCD value on port seg.
module score_bcd_display
  import score_pkg::*;
#(
  parameter int WIDTH  = SCORE_W,
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [WIDTH-1:0]      score,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
`ifdef SCORE_BCD_SEG_EN
  ,
  output logic [7*DIGITS-1:0]   seg
`endif
);

  localparam int                 BCD_W     = 4 * DIGITS;
  localparam int                 CNT_W     = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(WIDTH - 1);
  localparam logic [63:0]        BCD_MAX   = pow10(DIGITS) - 64'd1;
  localparam logic [BCD_W-1:0]   ALL_NINES = {DIGITS{4'h9}};

  state_t             state_reg;
  logic [WIDTH-1:0]   shift_reg;
  logic [BCD_W-1:0]   acc_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               ovf_pend_reg;

  logic [BCD_W-1:0]   acc_adj;
  logic [BCD_W-1:0]   acc_next;
  logic [WIDTH-1:0]   shift_next;
  logic               score_ovf;

  assign busy = (state_reg != ST_IDLE);

  // Overflow is decided on the sampled score, before any shifting
  assign score_ovf = (64'(score) > BCD_MAX);

  // Add-3 correction on every digit that would exceed 9 after doubling
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign acc_adj[4*gi +: 4] = (acc_reg[4*gi +: 4] >= 4'd5)
                                ? acc_reg[4*gi +: 4] + 4'd3
                                : acc_reg[4*gi +: 4];
    end
  endgenerate

  // Shift {accumulator, score} left by one; carry out of the top digit is dropped
  assign acc_next   = (acc_adj << 1) | BCD_W'(shift_reg[WIDTH-1]);
  assign shift_next = shift_reg << 1;

  // Converter FSM with registered done/bcd/ovf
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      shift_reg    <= '0;
      acc_reg      <= '0;
      cnt_reg      <= '0;
      ovf_pend_reg <= 1'b0;
      done         <= 1'b0;
      bcd          <= '0;
      ovf          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            shift_reg    <= score;
            acc_reg      <= '0;
            cnt_reg      <= '0;
            ovf_pend_reg <= score_ovf;
            state_reg    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          acc_reg   <= acc_next;
          shift_reg <= shift_next;
          cnt_reg   <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_LAST) begin
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          bcd       <= ovf_pend_reg ? ALL_NINES : acc_reg;
          ovf       <= ovf_pend_reg;
          done      <= 1'b1;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

`ifdef SCORE_BCD_SEG_EN
  logic [7*DIGITS-1:0] seg_dec;

  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_seg
      seg7_decode u_dec (
        .digit (bcd[4*gi +: 4]),
        .seg   (seg_dec[7*gi +: 7])
      );
    end
  endgenerate

  // Register the decoded glyphs so seg trails bcd by one cycle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      seg <= {DIGITS{SEG_0}};
    end else begin
      seg <= seg_dec;
    end
  end
`endif

endmodule

// File: tb/tb_score_bcd_display.sv
// Scoreboard bench for score_bcd_display. Two instances (8 and 6 digits)
// share stimulus; a decimal reference model predicts each accepted start
// and a negedge monitor checks every done pulse against the queue.
module tb_score_bcd_display;

  localparam int W    = 24;
  localparam int LAT  = W + 1;   // start edge to done edge
  localparam int GAP  = W + 2;   // earliest next accepted start edge

  typedef struct {
    logic [63:0] bcd8;
    logic        ovf8;
    logic [63:0] bcd6;
    logic        ovf6;
    int          edge_no;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [W-1:0]      score;
  logic              start;
  logic              busy8, done8, ovf8;
  logic              busy6, done6, ovf6;
  logic [31:0]       bcd8;
  logic [23:0]       bcd6;
`ifdef SCORE_BCD_SEG_EN
  logic [55:0]       seg8;
  logic [41:0]       seg6;
`endif

  int                n_vec = 0;
  int                n_bad = 0;
  int                edge_cnt = 0;
  int                last_k = -1000;
  exp_t              q[$];

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  score_bcd_display #(.WIDTH(W), .DIGITS(8)) dut8 (
    .clk     (clk),
    .reset_n (reset_n),
    .score   (score),
    .start   (start),
    .busy    (busy8),
    .done    (done8),
    .bcd     (bcd8),
    .ovf     (ovf8)
`ifdef SCORE_BCD_SEG_EN
    ,
    .seg     (seg8)
`endif
  );

  score_bcd_display #(.WIDTH(W), .DIGITS(6)) dut6 (
    .clk     (clk),
    .reset_n (reset_n),
    .score   (score),
    .start   (start),
    .busy    (busy6),
    .done    (done6),
    .bcd     (bcd6),
    .ovf     (ovf6)
`ifdef SCORE_BCD_SEG_EN
    ,
    .seg     (seg6)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Decimal reference: digits by repeated division, saturating to all nines
  function automatic logic [63:0] ref_bcd(input longint unsigned v, input int d, output logic ov);
    longint unsigned lim;
    logic [63:0]     r;
    lim = 1;
    for (int i = 0; i < d; i++) lim = lim * 10;
    ov = (v >= lim);
    r  = '0;
    for (int i = 0; i < d; i++) begin
      if (ov) begin
        r[4*i +: 4] = 4'd9;
      end else begin
        r[4*i +: 4] = 4'(v % 10);
        v = v / 10;
      end
    end
    return r;
  endfunction

  // Drive one cycle of stimulus; push a prediction if the model says it is accepted
  task automatic step(input logic s, input logic [W-1:0] sc);
    int   k;
    exp_t e;
    k     = edge_cnt + 1;
    start = s;
    score = sc;
    if (s && reset_n && (k - last_k >= GAP)) begin
      e.bcd8    = ref_bcd(longint'(sc), 8, e.ovf8);
      e.bcd6    = ref_bcd(longint'(sc), 6, e.ovf6);
      e.edge_no = k + LAT;
      q.push_back(e);
      last_k = k;
    end
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] rnd_score();
    case ($urandom_range(0, 2))
      0:       return W'($urandom_range(0, 999));
      1:       return W'($urandom_range(0, 999999));
      default: return W'($urandom);
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest prediction
`ifdef SCORE_BCD_SEG_EN
  logic        seg_pending = 1'b0;
  logic [55:0] seg_exp;
`endif
  always @(negedge clk) begin
    exp_t e;
`ifdef SCORE_BCD_SEG_EN
    if (seg_pending) begin
      chk("seg8", 64'(seg8), 64'(seg_exp));
      seg_pending = 1'b0;
    end
`endif
    if (done8 || done6) begin
      if (q.size() == 0) begin
        chk("spurious_done", 64'(1), 64'(0));
      end else begin
        e = q.pop_front();
        $display("done at edge %0d: bcd8=%h ovf8=%b bcd6=%h ovf6=%b", edge_cnt, bcd8, ovf8, bcd6, ovf6);
        chk("done_edge", 64'(edge_cnt), 64'(e.edge_no));
        chk("done8", 64'(done8), 64'(1));
        chk("done6", 64'(done6), 64'(1));
        chk("bcd8", 64'(bcd8), e.bcd8);
        chk("ovf8", 64'(ovf8), 64'(e.ovf8));
        chk("bcd6", 64'(bcd6), e.bcd6);
        chk("ovf6", 64'(ovf6), 64'(e.ovf6));
`ifdef SCORE_BCD_SEG_EN
        for (int i = 0; i < 8; i++) seg_exp[7*i +: 7] = seg_tab[e.bcd8[4*i +: 4]];
        seg_pending = 1'b1;
`endif
      end
    end
  end

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_busy8"}, 64'(busy8), 64'(0));
    chk({tag, "_done8"}, 64'(done8), 64'(0));
    chk({tag, "_bcd8"},  64'(bcd8),  64'(0));
    chk({tag, "_ovf8"},  64'(ovf8),  64'(0));
    chk({tag, "_busy6"}, 64'(busy6), 64'(0));
    chk({tag, "_bcd6"},  64'(bcd6),  64'(0));
`ifdef SCORE_BCD_SEG_EN
    chk({tag, "_seg8"},  64'(seg8),  64'({8{7'b1000000}}));
    chk({tag, "_seg6"},  64'(seg6),  64'({6{7'b1000000}}));
`endif
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    score   = '0;
    repeat (2) @(negedge clk);
    chk_idle_zero("reset");
    reset_n = 1'b1;
    step(1'b0, '0);

    // 1234567: busy for exactly 25 cycles
    step(1'b1, W'(1234567));
    for (int i = 0; i < LAT; i++) begin
      chk("busy_hi", 64'(busy8), 64'(1));
      step(1'b0, W'($urandom));
    end
    chk("busy_lo", 64'(busy8), 64'(0));
    repeat (3) step(1'b0, W'($urandom));

    // Largest score: fits in 8 digits, saturates 6 digits
    step(1'b1, 24'hFFFFFF);
    repeat (30) step(1'b0, W'($urandom));

    // 42 accepted, 99 ignored while busy, then 99 converted from idle
    step(1'b1, W'(42));
    repeat (4) step(1'b0, W'($urandom));
    step(1'b1, W'(99));
    repeat (30) step(1'b0, W'($urandom));
    step(1'b1, W'(99));
    repeat (30) step(1'b0, W'($urandom));

    // Reset mid-conversion aborts with no done and clears bcd
    step(1'b1, W'(500));
    repeat (9) step(1'b0, W'($urandom));
    reset_n = 1'b0;
    q.delete();
    step(1'b0, W'($urandom));
    chk_idle_zero("abort");
    reset_n = 1'b1;
    last_k  = -1000;
    repeat (3) step(1'b0, W'($urandom));
    step(1'b1, W'(81));
    repeat (30) step(1'b0, W'($urandom));

    // Start held high: back-to-back conversions with changing score
    for (int i = 0; i < 60; i++) step(1'b1, rnd_score());

    // Random starts with random idle gaps
    for (int n = 0; n < 40; n++) begin
      step(1'b1, rnd_score());
      repeat ($urandom_range(0, 30)) step(1'b0, W'($urandom));
    end

    // Drain outstanding conversions with a bounded wait
    for (int i = 0; i < 40 && q.size() != 0; i++) step(1'b0, '0);
    step(1'b0, '0);
    chk("pending_done", 64'(q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
